// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
//
// Multi-channel tick generator. Each of the NUM_CH channels is an independent
// prescaler. It has a runtime-programmable terminal count, per-channel run and
// restart controls, and a registered single-cycle tick output. Downstream time
// counters, the stopwatch and the debounce samplers use the ticks as clock
// enables.
//
// Optional feature macro: GEN_ONESHOT_EN
//   When defined, every channel gets a mode bit that is written together with
//   its terminal count. In one-shot mode the channel ticks once, disarms itself
//   on that same edge and stays idle until it is restarted.
//   When undefined, wr_oneshot is ignored and every channel is periodic.
//
// Parameters
//   NUM_CH   number of tick channels (1..16)
//   CNT_W    counter / terminal-count width in bits
//   DEF_TERM terminal count loaded at reset (period = DEF_TERM+1 cycles)
//   CH_W     width of wr_ch, must be >= clog2(NUM_CH), minimum 1
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low reset
//   run         per-channel count enable
//   restart     per-channel synchronous restart (clear counter, re-arm)
//   wr_en       terminal-count write strobe
//   wr_ch       channel targeted by the write
//   wr_data     new terminal count
//   wr_oneshot  mode written with the term (1 = one-shot), macro builds only
//   tick        registered one-cycle pulse per channel period
//   armed       1 while the channel is able to count
// -----------------------------------------------------------------------------
module multi_tick_gen #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 19,
   parameter int DEF_TERM = 499999,
   parameter int CH_W     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] run,
   input  logic [NUM_CH-1:0] restart,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_data,
   input  logic              wr_oneshot,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] armed
);

   localparam logic [CNT_W-1:0] DEF_TERM_V = CNT_W'(DEF_TERM);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifndef GEN_ONESHOT_EN
   // Without the one-shot feature the mode input has no destination.
   logic unused_wr_oneshot;
   assign unused_wr_oneshot = wr_oneshot;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] term;
      logic             tick_q;
      logic             armed_q;
      logic             wr_hit;
      logic             at_term;
`ifdef GEN_ONESHOT_EN
      logic             mode;   // 1 = one-shot, 0 = periodic
`endif

      // CH_W is wide enough to hold every channel index, so an exact match on
      // i can only happen for wr_ch < NUM_CH; out-of-range writes hit nobody.
      assign wr_hit  = wr_en && (wr_ch == CH_W'(i));

      // >= instead of == so that a freshly written term smaller than the
      // current count wraps immediately instead of running to 2^CNT_W.
      // The counter only increments while below term, so it never overflows.
      assign at_term = (cnt >= term);

      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt     <= '0;
            term    <= DEF_TERM_V;
            tick_q  <= 1'b0;
            armed_q <= 1'b1;
`ifdef GEN_ONESHOT_EN
            mode    <= 1'b0;
`endif
         end else begin
            if (restart[i]) begin
               cnt     <= '0;
               tick_q  <= 1'b0;
               armed_q <= 1'b1;
            end else if (run[i] && armed_q) begin
               if (at_term) begin
                  cnt    <= '0;
                  tick_q <= 1'b1;
`ifdef GEN_ONESHOT_EN
                  // A one-shot channel disarms on its tick edge; cnt is
                  // already 0 and stays there until the next restart.
                  if (mode) begin
                     armed_q <= 1'b0;
                  end
`endif
               end else begin
                  cnt    <= cnt + CNT_ONE;
                  tick_q <= 1'b0;
               end
            end else begin
               // Stopped or disarmed: counter holds, no tick.
               tick_q <= 1'b0;
            end

            // Terminal-count write is independent of restart/counting: the
            // compare above used the old term, the new one applies from the
            // next edge, and cnt is left alone.
            if (wr_hit) begin
               term <= wr_data;
`ifdef GEN_ONESHOT_EN
               mode <= wr_oneshot;
`endif
            end
         end
      end

      assign tick[i]  = tick_q;
      assign armed[i] = armed_q;
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_tick_gen
//
// Bench for multi_tick_gen. The instance uses a reduced counter width and
// default term so that every scenario, including the full-scale term, fits in
// a short run. A behavioural model tracks, per channel, how many running
// cycles have elapsed since the last wrap and the programmed term. It predicts
// tick/armed after every edge through an expected queue. Directed scenarios
// additionally measure tick spacing against fixed period numbers.
// -----------------------------------------------------------------------------
module tb_multi_tick_gen;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 8;
   localparam int DEF_TERM = 99;
   localparam int CH_W     = 3;
   localparam int MAX_TERM = (1 << CNT_W) - 1;
`ifdef GEN_ONESHOT_EN
   localparam bit ONESHOT  = 1'b1;
`else
   localparam bit ONESHOT  = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] run;
   logic [NUM_CH-1:0] restart;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [CNT_W-1:0]  wr_data;
   logic              wr_oneshot;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] armed;

   always #5 clk = ~clk;

   multi_tick_gen #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_TERM(DEF_TERM),
      .CH_W    (CH_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .restart   (restart),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_data   (wr_data),
      .wr_oneshot(wr_oneshot),
      .tick      (tick),
      .armed     (armed)
   );

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_err  = 0;
   int edge_n = 0;
   logic [2*NUM_CH-1:0] exp_q[$];

   // Reference model state
   int m_elapsed[NUM_CH];
   int m_term[NUM_CH];
   bit m_armed[NUM_CH];
   bit m_oneshot[NUM_CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
      end
   endtask

   // Predict the outputs after the coming edge from the inputs now applied.
   task automatic model_step();
      logic [NUM_CH-1:0] e_tick;
      logic [NUM_CH-1:0] e_armed;
      e_tick  = '0;
      e_armed = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!reset) begin
            m_elapsed[c] = 0;
            m_term[c]    = DEF_TERM;
            m_armed[c]   = 1'b1;
            m_oneshot[c] = 1'b0;
         end else begin
            if (restart[c]) begin
               m_elapsed[c] = 0;
               m_armed[c]   = 1'b1;
            end else if (run[c] && m_armed[c]) begin
               if (m_elapsed[c] >= m_term[c]) begin
                  m_elapsed[c] = 0;
                  e_tick[c]    = 1'b1;
                  if (ONESHOT && m_oneshot[c]) m_armed[c] = 1'b0;
               end else begin
                  m_elapsed[c] = m_elapsed[c] + 1;
               end
            end
            if (wr_en && int'(wr_ch) == c) begin
               m_term[c]    = int'(wr_data);
               m_oneshot[c] = wr_oneshot;
            end
         end
         e_armed[c] = m_armed[c];
      end
      exp_q.push_back({e_armed, e_tick});
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      logic [2*NUM_CH-1:0] e;
      model_step();
      @(posedge clk);
      #1;
      edge_n++;
      e = exp_q.pop_front();
      check("tick",  32'(tick),  32'(e[NUM_CH-1:0]));
      check("armed", 32'(armed), 32'(e[2*NUM_CH-1:NUM_CH]));
   endtask

   task automatic write_term(input int ch, input int val, input bit os);
      wr_en      = 1'b1;
      wr_ch      = CH_W'(ch);
      wr_data    = CNT_W'(val);
      wr_oneshot = os;
      cycle();
      wr_en      = 1'b0;
      wr_oneshot = 1'b0;
   endtask

   task automatic do_restart(input int ch, output int at);
      restart[ch] = 1'b1;
      cycle();
      at = edge_n;
      restart[ch] = 1'b0;
   endtask

   // Run cycles until tick[ch] is seen; returns the edge index or -1.
   task automatic wait_tick(input int ch, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         cycle();
         if (tick[ch] === 1'b1) begin
            at = edge_n;
            break;
         end
      end
      if (at < 0) check("tick_wait_timeout", 32'(tick[ch]), 32'd1);
   endtask

   task automatic count_ticks(input int ch, input int ncyc, output int n);
      n = 0;
      for (int k = 0; k < ncyc; k++) begin
         cycle();
         if (tick[ch] === 1'b1) n++;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0, t1, t2, k, n, rel;
      reset      = 1'b0;
      run        = 4'b0001;
      restart    = '0;
      wr_en      = 1'b0;
      wr_ch      = '0;
      wr_data    = '0;
      wr_oneshot = 1'b0;

      // Reset and default period on channel 0
      repeat (3) cycle();
      check("armed_in_reset", 32'(armed), 32'hF);
      check("tick_in_reset",  32'(tick),  32'h0);
      rel   = edge_n;
      reset = 1'b1;
      wait_tick(0, 150, t0);
      check("default_first_tick", 32'(t0 - rel), 32'(DEF_TERM + 1));
      wait_tick(0, 150, t1);
      check("default_period", 32'(t1 - t0), 32'(DEF_TERM + 1));

      // Programmed term on channel 2, then shrink mid-period
      run = 4'b0000;
      write_term(2, 9, 1'b0);
      do_restart(2, k);
      run[2] = 1'b1;
      wait_tick(2, 30, t0);
      check("restart_first_tick", 32'(t0 - k), 32'd10);
      wait_tick(2, 30, t1);
      check("term9_period", 32'(t1 - t0), 32'd10);
      repeat (7) cycle();
      write_term(2, 3, 1'b0);
      k = edge_n;
      wait_tick(2, 10, t0);
      check("shrink_latency", 32'(t0 - k), 32'd1);
      wait_tick(2, 10, t1);
      check("term3_period", 32'(t1 - t0), 32'd4);

      // Run gating stretches exactly one period
      run = 4'b0000;
      write_term(1, 4, 1'b0);
      do_restart(1, k);
      run[1] = 1'b1;
      wait_tick(1, 20, t0);
      repeat (2) cycle();
      run[1] = 1'b0;
      repeat (3) cycle();
      run[1] = 1'b1;
      wait_tick(1, 20, t1);
      check("gated_period", 32'(t1 - t0), 32'd8);
      wait_tick(1, 20, t2);
      check("after_gate_period", 32'(t2 - t1), 32'd5);

      // term = 0 ticks on every running cycle
      run = 4'b0000;
      write_term(3, 0, 1'b0);
      do_restart(3, k);
      run[3] = 1'b1;
      count_ticks(3, 10, n);
      check("term0_ticks", 32'(n), 32'd10);

      // Full-scale term on channel 0
      run = 4'b0001;
      write_term(0, MAX_TERM, 1'b0);
      do_restart(0, k);
      wait_tick(0, 300, t0);
      check("max_term_first", 32'(t0 - k), 32'(MAX_TERM + 1));
      wait_tick(0, 300, t1);
      check("max_term_period", 32'(t1 - t0), 32'(MAX_TERM + 1));

      // Out-of-range channel write leaves everything alone
      write_term(5, 1, 1'b1);
      wait_tick(0, 300, t2);
      check("bad_ch_write", 32'(t2 - t1), 32'(MAX_TERM + 1));

      // Restart and write on the same channel in the same cycle
      restart[0] = 1'b1;
      wr_en      = 1'b1;
      wr_ch      = '0;
      wr_data    = CNT_W'(6);
      cycle();
      k          = edge_n;
      restart[0] = 1'b0;
      wr_en      = 1'b0;
      wait_tick(0, 20, t0);
      check("restart_write_first", 32'(t0 - k), 32'd7);
      wait_tick(0, 20, t1);
      check("restart_write_period", 32'(t1 - t0), 32'd7);

      // Reset mid-count restores default terms on every channel
      run = 4'b1111;
      repeat (3) cycle();
      reset = 1'b0;
      cycle();
      check("midreset_tick",  32'(tick),  32'h0);
      check("midreset_armed", 32'(armed), 32'hF);
      rel   = edge_n;
      reset = 1'b1;
      wait_tick(0, 150, t0);
      check("midreset_first", 32'(t0 - rel), 32'(DEF_TERM + 1));
      check("simultaneous_ticks", 32'(tick), 32'hF);

      // One-shot mode (periodic without the macro)
      run = 4'b0010;
      write_term(1, 5, 1'b1);
      do_restart(1, k);
      wait_tick(1, 20, t0);
      check("oneshot_first", 32'(t0 - k), 32'd6);
      count_ticks(1, 100, n);
`ifdef GEN_ONESHOT_EN
      check("oneshot_quiet", 32'(n), 32'd0);
      check("oneshot_disarmed", 32'(armed[1]), 32'd0);
      do_restart(1, k);
      wait_tick(1, 20, t1);
      check("oneshot_rearm", 32'(t1 - k), 32'd6);
      count_ticks(1, 20, n);
      check("oneshot_quiet2", 32'(n), 32'd0);
`else
      check("periodic_count", 32'(n), 32'd16);
      check("periodic_armed", 32'(armed[1]), 32'd1);
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         run     = NUM_CH'($urandom_range(0, 15));
         restart = '0;
         if ($urandom_range(0, 19) == 0) restart = NUM_CH'($urandom_range(1, 15));
         wr_en      = ($urandom_range(0, 7) == 0);
         wr_ch      = CH_W'($urandom_range(0, 7));
         wr_data    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, MAX_TERM))
                                                  : CNT_W'($urandom_range(0, 12));
         wr_oneshot = $urandom_range(0, 1);
         reset      = ($urandom_range(0, 499) != 0);
         cycle();
      end
      reset   = 1'b1;
      wr_en   = 1'b0;
      restart = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
